// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions: opcode macros (also used by execute), the decoded-field
// record and the immediate-format selector.
`ifndef RV_DEFS_V
`define RV_DEFS_V
`define RV_OP_LOAD     5'b00000
`define RV_OP_MISC_MEM 5'b00011
`define RV_OP_OP_IMM   5'b00100
`define RV_OP_AUIPC    5'b00101
`define RV_OP_STORE    5'b01000
`define RV_OP_OP       5'b01100
`define RV_OP_LUI      5'b01101
`define RV_OP_BRANCH   5'b11000
`define RV_OP_JALR     5'b11001
`define RV_OP_JAL      5'b11011
`define RV_OP_SYSTEM   5'b11100
`endif

package rv_decode_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [2:0]  fun3;
        logic        fun7_bit;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        illegal;
    } dec_fields_t;

    function automatic logic is_rv32i_opcode(input logic [4:0] op);
        case (op)
            `RV_OP_LOAD, `RV_OP_MISC_MEM, `RV_OP_OP_IMM, `RV_OP_AUIPC,
            `RV_OP_STORE, `RV_OP_OP, `RV_OP_LUI, `RV_OP_BRANCH,
            `RV_OP_JALR, `RV_OP_JAL, `RV_OP_SYSTEM: is_rv32i_opcode = 1'b1;
            default:                                is_rv32i_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate extraction: one sign-extended immediate per RV32I format.
module rv_imm_gen
    import rv_decode_pkg::*;
(
    input  logic [31:0] i_ir,
    output logic [31:0] o_imm_i,
    output logic [31:0] o_imm_s,
    output logic [31:0] o_imm_b,
    output logic [31:0] o_imm_u,
    output logic [31:0] o_imm_j
);

    assign o_imm_i = {{20{i_ir[31]}}, i_ir[31:20]};
    assign o_imm_s = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
    assign o_imm_b = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
    assign o_imm_u = {i_ir[31:12], 12'h000};
    assign o_imm_j = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};

endmodule

// File: rtl/rv_decode.sv
// uRV decode stage: registers the fetched instruction, decodes fields/immediates/class,
// and inserts one bubble per load-use hazard while back-pressuring fetch.
module rv_decode
    import rv_decode_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] f_ir_i,
    input  logic [31:0] f_pc_i,
    input  logic        f_valid_i,
    input  logic        d_stall_i,
    input  logic        d_kill_i,
    output logic        d_stall_req_o,
    output logic [4:0]  rf_rs1_o,
    output logic [4:0]  rf_rs2_o,
    output logic        d_valid_o,
    output logic [31:0] d_pc_o,
    output logic [4:0]  d_opcode_o,
    output logic [2:0]  d_fun3_o,
    output logic        d_fun7_bit_o,
    output logic [4:0]  d_rs1_o,
    output logic [4:0]  d_rs2_o,
    output logic [4:0]  d_rd_o,
    output logic [31:0] d_imm_o,
    output logic        d_is_load_o,
    output logic        d_is_store_o,
    output logic        d_is_branch_o,
    output logic        d_is_jal_o,
    output logic        d_is_jalr_o,
    output logic        d_illegal_o
);

    logic [4:0]  w_op;
    logic        w_legal;
    logic        w_rs1_used;
    logic        w_rs2_used;
    logic        w_rd_wr;
    imm_fmt_e    w_fmt;
    dec_fields_t w_dec;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic        w_load_hazard;

    logic        r_valid;
    logic [31:0] r_pc;
    dec_fields_t r_dec;

    assign w_op = f_ir_i[6:2];

    rv_imm_gen u_imm_gen (
        .i_ir    (f_ir_i),
        .o_imm_i (w_imm_i),
        .o_imm_s (w_imm_s),
        .o_imm_b (w_imm_b),
        .o_imm_u (w_imm_u),
        .o_imm_j (w_imm_j)
    );

    // Decode f_ir_i into the register-file record; illegal words keep no operands, rd or class.
    always_comb begin
        w_legal      = (f_ir_i[1:0] == 2'b11) && is_rv32i_opcode(w_op);
        w_rs1_used   = 1'b0;
        w_rs2_used   = 1'b0;
        w_rd_wr      = 1'b0;
        w_fmt        = FMT_R;
        w_dec        = '0;
        w_dec.opcode   = w_op;
        w_dec.fun3     = f_ir_i[14:12];
        w_dec.fun7_bit = f_ir_i[30];
        w_dec.illegal  = !w_legal;
        if (w_legal) begin
            w_rs1_used = 1'b1;
            w_rd_wr    = 1'b1;
            case (w_op)
                `RV_OP_LOAD:     begin w_fmt = FMT_I; w_dec.is_load = 1'b1; end
                `RV_OP_MISC_MEM: begin w_fmt = FMT_I; w_rd_wr = 1'b0; end
                `RV_OP_OP_IMM:   w_fmt = FMT_I;
                `RV_OP_AUIPC:    begin w_fmt = FMT_U; w_rs1_used = 1'b0; end
                `RV_OP_STORE:    begin
                    w_fmt = FMT_S; w_rs2_used = 1'b1; w_rd_wr = 1'b0; w_dec.is_store = 1'b1;
                end
                `RV_OP_OP:       w_rs2_used = 1'b1;
                `RV_OP_LUI:      begin w_fmt = FMT_U; w_rs1_used = 1'b0; end
                `RV_OP_BRANCH:   begin
                    w_fmt = FMT_B; w_rs2_used = 1'b1; w_rd_wr = 1'b0; w_dec.is_branch = 1'b1;
                end
                `RV_OP_JALR:     begin w_fmt = FMT_I; w_dec.is_jalr = 1'b1; end
                `RV_OP_JAL:      begin w_fmt = FMT_J; w_rs1_used = 1'b0; w_dec.is_jal = 1'b1; end
                `RV_OP_SYSTEM:   begin w_fmt = FMT_I; w_rd_wr = (f_ir_i[14:12] != 3'b000); end
                default:         begin w_rs1_used = 1'b0; w_rd_wr = 1'b0; end
            endcase
        end else begin
            w_fmt = FMT_R;
        end
        w_dec.rs1 = w_rs1_used ? f_ir_i[19:15] : 5'd0;
        w_dec.rs2 = w_rs2_used ? f_ir_i[24:20] : 5'd0;
        w_dec.rd  = w_rd_wr    ? f_ir_i[11:7]  : 5'd0;
        case (w_fmt)
            FMT_I:   w_dec.imm = w_imm_i;
            FMT_S:   w_dec.imm = w_imm_s;
            FMT_B:   w_dec.imm = w_imm_b;
            FMT_U:   w_dec.imm = w_imm_u;
            FMT_J:   w_dec.imm = w_imm_j;
            default: w_dec.imm = 32'h0000_0000;
        endcase
    end

    // A load in decode whose rd (never x0) feeds the incoming instruction costs one bubble.
    assign w_load_hazard = f_valid_i & r_valid & r_dec.is_load & (r_dec.rd != 5'd0) &
                           ((w_rs1_used & (f_ir_i[19:15] == r_dec.rd)) |
                            (w_rs2_used & (f_ir_i[24:20] == r_dec.rd)));

    assign d_stall_req_o = d_stall_i | w_load_hazard;
    assign rf_rs1_o      = f_ir_i[19:15];
    assign rf_rs2_o      = f_ir_i[24:20];

    // Decode output register: kill beats stall beats hazard bubble beats capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_pc    <= 32'h0000_0000;
            r_dec   <= '0;
        end else if (d_kill_i) begin
            r_valid <= 1'b0;
        end else if (d_stall_i) begin
            r_valid <= r_valid;
        end else if (w_load_hazard) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= f_valid_i;
            r_pc    <= f_pc_i;
            r_dec   <= w_dec;
        end
    end

    assign d_valid_o     = r_valid;
    assign d_pc_o        = r_pc;
    assign d_opcode_o    = r_dec.opcode;
    assign d_fun3_o      = r_dec.fun3;
    assign d_fun7_bit_o  = r_dec.fun7_bit;
    assign d_rs1_o       = r_dec.rs1;
    assign d_rs2_o       = r_dec.rs2;
    assign d_rd_o        = r_dec.rd;
    assign d_imm_o       = r_dec.imm;
    assign d_is_load_o   = r_dec.is_load;
    assign d_is_store_o  = r_dec.is_store;
    assign d_is_branch_o = r_dec.is_branch;
    assign d_is_jal_o    = r_dec.is_jal;
    assign d_is_jalr_o   = r_dec.is_jalr;
    assign d_illegal_o   = r_dec.illegal;

endmodule

// File: tb/tb_rv_decode.sv
// Self-checking bench for rv_decode: directed scenarios plus randomized traffic against
// an instruction-level reference model of the decode stage.
module tb_rv_decode;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  opcode;
        logic [2:0]  fun3;
        logic        fun7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ld, st, br, jal, jalr, ill;
    } obs_t;

    logic        clk_i, rst_i;
    logic [31:0] f_ir_i, f_pc_i;
    logic        f_valid_i, d_stall_i, d_kill_i;
    logic        d_stall_req_o, d_valid_o, d_fun7_bit_o;
    logic [4:0]  rf_rs1_o, rf_rs2_o, d_opcode_o, d_rs1_o, d_rs2_o, d_rd_o;
    logic [2:0]  d_fun3_o;
    logic [31:0] d_pc_o, d_imm_o;
    logic        d_is_load_o, d_is_store_o, d_is_branch_o, d_is_jal_o, d_is_jalr_o, d_illegal_o;

    int   n_cmp = 0;
    int   n_fail = 0;
    logic m_valid;
    obs_t m_obs;

    rv_decode dut (
        .clk_i(clk_i), .rst_i(rst_i), .f_ir_i(f_ir_i), .f_pc_i(f_pc_i), .f_valid_i(f_valid_i),
        .d_stall_i(d_stall_i), .d_kill_i(d_kill_i), .d_stall_req_o(d_stall_req_o),
        .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o), .d_valid_o(d_valid_o), .d_pc_o(d_pc_o),
        .d_opcode_o(d_opcode_o), .d_fun3_o(d_fun3_o), .d_fun7_bit_o(d_fun7_bit_o),
        .d_rs1_o(d_rs1_o), .d_rs2_o(d_rs2_o), .d_rd_o(d_rd_o), .d_imm_o(d_imm_o),
        .d_is_load_o(d_is_load_o), .d_is_store_o(d_is_store_o), .d_is_branch_o(d_is_branch_o),
        .d_is_jal_o(d_is_jal_o), .d_is_jalr_o(d_is_jalr_o), .d_illegal_o(d_illegal_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic obs_t dut_obs();
        return {d_pc_o, d_opcode_o, d_fun3_o, d_fun7_bit_o, d_rs1_o, d_rs2_o, d_rd_o, d_imm_o,
                d_is_load_o, d_is_store_o, d_is_branch_o, d_is_jal_o, d_is_jalr_o, d_illegal_o};
    endfunction

    // Reference decode straight from the RV32I opcode table and immediate bit layouts.
    function automatic obs_t ref_decode(input logic [31:0] ir, input logic [31:0] pc);
        obs_t o;
        logic u1, u2, wr, legal;
        logic [31:0] imm;
        o = '0;
        o.pc = pc; o.opcode = ir[6:2]; o.fun3 = ir[14:12]; o.fun7 = ir[30];
        u1 = 1'b0; u2 = 1'b0; wr = 1'b0; legal = 1'b1; imm = 32'h0;
        case (ir[6:0])
            7'h03: begin u1 = 1'b1; wr = 1'b1; o.ld = 1'b1; imm = int'($signed(ir[31:20])); end
            7'h0F: begin u1 = 1'b1; imm = int'($signed(ir[31:20])); end
            7'h13: begin u1 = 1'b1; wr = 1'b1; imm = int'($signed(ir[31:20])); end
            7'h17: begin wr = 1'b1; imm = {ir[31:12], 12'h000}; end
            7'h23: begin u1 = 1'b1; u2 = 1'b1; o.st = 1'b1; imm = int'($signed({ir[31:25], ir[11:7]})); end
            7'h33: begin u1 = 1'b1; u2 = 1'b1; wr = 1'b1; end
            7'h37: begin wr = 1'b1; imm = {ir[31:12], 12'h000}; end
            7'h63: begin
                u1 = 1'b1; u2 = 1'b1; o.br = 1'b1;
                imm = int'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
            end
            7'h67: begin u1 = 1'b1; wr = 1'b1; o.jalr = 1'b1; imm = int'($signed(ir[31:20])); end
            7'h6F: begin
                wr = 1'b1; o.jal = 1'b1;
                imm = int'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
            end
            7'h73: begin u1 = 1'b1; wr = (ir[14:12] != 3'd0); imm = int'($signed(ir[31:20])); end
            default: legal = 1'b0;
        endcase
        o.rs1 = u1 ? ir[19:15] : 5'd0;
        o.rs2 = u2 ? ir[24:20] : 5'd0;
        o.rd  = wr ? ir[11:7]  : 5'd0;
        o.imm = imm;
        o.ill = !legal;
        return o;
    endfunction

    function automatic logic model_hazard();
        obs_t fd;
        fd = ref_decode(f_ir_i, f_pc_i);
        return f_valid_i && m_valid && m_obs.ld && (m_obs.rd != 5'd0) &&
               ((fd.rs1 == m_obs.rd) || (fd.rs2 == m_obs.rd));
    endfunction

    function automatic logic model_stall_req();
        return d_stall_i || model_hazard();
    endfunction

    // One clock: the model advances from the inputs present before the edge.
    task automatic tick();
        obs_t fd;
        logic haz, k, s, r, fv;
        fd = ref_decode(f_ir_i, f_pc_i);
        haz = model_hazard();
        k = d_kill_i; s = d_stall_i; r = rst_i; fv = f_valid_i;
        @(posedge clk_i);
        if (r) begin
            m_valid = 1'b0; m_obs = '0;
        end else if (k) begin
            m_valid = 1'b0;
        end else if (s) begin
            m_valid = m_valid;
        end else if (haz) begin
            m_valid = 1'b0;
        end else begin
            m_valid = fv; m_obs = fd;
        end
        #1;
    endtask

    function automatic logic [31:0] rand_ir();
        logic [31:0] ir;
        ir = $urandom;
        case ($urandom_range(0, 13))
            0, 12:   ir[6:0] = 7'h03;
            1:       ir[6:0] = 7'h0F;
            2, 13:   ir[6:0] = 7'h13;
            3:       ir[6:0] = 7'h17;
            4:       ir[6:0] = 7'h23;
            5:       ir[6:0] = 7'h33;
            6:       ir[6:0] = 7'h37;
            7:       ir[6:0] = 7'h63;
            8:       ir[6:0] = 7'h67;
            9:       ir[6:0] = 7'h6F;
            10:      ir[6:0] = 7'h73;
            default: ir[6:0] = ir[6:0];
        endcase
        if ($urandom_range(0, 3) != 0) begin
            ir[19:15] = 5'($urandom_range(0, 3));
            ir[24:20] = 5'($urandom_range(0, 3));
            ir[11:7]  = 5'($urandom_range(0, 3));
        end
        return ir;
    endfunction

    task automatic drive(input logic [31:0] ir, input logic [31:0] pc);
        f_ir_i = ir; f_pc_i = pc; f_valid_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; d_stall_i = 1'b0; d_kill_i = 1'b0;
        drive(32'h0050_0093, 32'h0000_0010);
        tick(); tick();
        n_cmp++;
        if (d_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got=%b want=0", d_valid_o);
        end
        n_cmp++;
        if (dut_obs() !== obs_t'('0)) begin
            n_fail++; $display("FAIL reset_fields got=%h want=0", dut_obs());
        end
        d_stall_i = 1'b1; #1;
        n_cmp++;
        if (d_stall_req_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_stallreq_hi got=%b want=1", d_stall_req_o);
        end
        d_stall_i = 1'b0; #1;
        n_cmp++;
        if (d_stall_req_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_stallreq_lo got=%b want=0", d_stall_req_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_addi();
        drive(32'h0050_0093, 32'h0000_0100);
        tick();
        n_cmp++;
        if ({d_valid_o, d_rd_o, d_rs1_o, d_rs2_o, d_imm_o, d_opcode_o} !==
            {1'b1, 5'd1, 5'd0, 5'd0, 32'h0000_0005, 5'b00100}) begin
            n_fail++;
            $display("FAIL addi got v=%b rd=%0d rs1=%0d rs2=%0d imm=%h op=%b want v=1 rd=1 rs1=0 rs2=0 imm=5 op=00100",
                     d_valid_o, d_rd_o, d_rs1_o, d_rs2_o, d_imm_o, d_opcode_o);
        end
        n_cmp++;
        if (dut_obs() !== m_obs) begin
            n_fail++; $display("FAIL addi_model got=%h want=%h", dut_obs(), m_obs);
        end
    endtask

    task automatic test_load_use();
        drive(32'h0000_A103, 32'h0000_0200);
        tick();
        n_cmp++;
        if ({d_valid_o, d_is_load_o, d_rd_o} !== {1'b1, 1'b1, 5'd2}) begin
            n_fail++; $display("FAIL lw got v=%b ld=%b rd=%0d want 1 1 2", d_valid_o, d_is_load_o, d_rd_o);
        end
        drive(32'h0021_01B3, 32'h0000_0204);
        #1;
        n_cmp++;
        if (d_stall_req_o !== 1'b1) begin
            n_fail++; $display("FAIL lu_stallreq got=%b want=1", d_stall_req_o);
        end
        tick();
        n_cmp++;
        if ({d_valid_o, d_stall_req_o} !== 2'b00) begin
            n_fail++; $display("FAIL lu_bubble got v=%b req=%b want v=0 req=0", d_valid_o, d_stall_req_o);
        end
        tick();
        n_cmp++;
        if ({d_valid_o, d_rs1_o, d_rs2_o, d_rd_o, d_pc_o} !== {1'b1, 5'd2, 5'd2, 5'd3, 32'h0000_0204}) begin
            n_fail++;
            $display("FAIL lu_add got v=%b rs1=%0d rs2=%0d rd=%0d pc=%h want 1 2 2 3 204",
                     d_valid_o, d_rs1_o, d_rs2_o, d_rd_o, d_pc_o);
        end
    endtask

    task automatic test_branch();
        drive(32'hFE00_0EE3, 32'h0000_0300);
        tick();
        n_cmp++;
        if ({d_valid_o, d_is_branch_o, d_imm_o, d_rd_o} !== {1'b1, 1'b1, 32'hFFFF_FFFC, 5'd0}) begin
            n_fail++;
            $display("FAIL beq got v=%b br=%b imm=%h rd=%0d want 1 1 fffffffc 0",
                     d_valid_o, d_is_branch_o, d_imm_o, d_rd_o);
        end
    endtask

    task automatic test_stall();
        obs_t want;
        want = ref_decode(32'h0070_0293, 32'h0000_0400);
        drive(32'h0070_0293, 32'h0000_0400);
        tick();
        d_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(rand_ir(), $urandom);
            #1;
            n_cmp++;
            if (d_stall_req_o !== 1'b1) begin
                n_fail++; $display("FAIL stall_req cyc=%0d got=%b want=1", i, d_stall_req_o);
            end
            tick();
            n_cmp++;
            if ({d_valid_o, dut_obs()} !== {1'b1, want}) begin
                n_fail++; $display("FAIL stall_hold cyc=%0d got=%b/%h want=1/%h", i, d_valid_o, dut_obs(), want);
            end
        end
        d_stall_i = 1'b0;
        drive(32'h0021_01B3, 32'h0000_0500);
        tick();
        n_cmp++;
        if ({d_valid_o, d_pc_o, d_rd_o} !== {1'b1, 32'h0000_0500, 5'd3}) begin
            n_fail++; $display("FAIL stall_release got v=%b pc=%h rd=%0d want 1 500 3", d_valid_o, d_pc_o, d_rd_o);
        end
    endtask

    task automatic test_kill();
        drive(32'h0050_0093, 32'h0000_0600); d_kill_i = 1'b1;
        tick();
        n_cmp++;
        if (d_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL kill_plain got=%b want=0", d_valid_o);
        end
        d_kill_i = 1'b0; drive(32'h0050_0093, 32'h0000_0604);
        tick();
        n_cmp++;
        if ({d_valid_o, d_pc_o} !== {1'b1, 32'h0000_0604}) begin
            n_fail++; $display("FAIL kill_plain_next got v=%b pc=%h want 1 604", d_valid_o, d_pc_o);
        end
        d_kill_i = 1'b1; d_stall_i = 1'b1; drive(32'h0070_0293, 32'h0000_0700);
        tick();
        n_cmp++;
        if (d_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL kill_stall got=%b want=0", d_valid_o);
        end
        d_kill_i = 1'b0; d_stall_i = 1'b0;
        tick();
        n_cmp++;
        if ({d_valid_o, d_pc_o} !== {1'b1, 32'h0000_0700}) begin
            n_fail++; $display("FAIL kill_stall_next got v=%b pc=%h want 1 700", d_valid_o, d_pc_o);
        end
        drive(32'h0000_A103, 32'h0000_0800);
        tick();
        drive(32'h0021_01B3, 32'h0000_0804); d_kill_i = 1'b1;
        #1;
        n_cmp++;
        if (d_stall_req_o !== 1'b1) begin
            n_fail++; $display("FAIL kill_haz_req got=%b want=1", d_stall_req_o);
        end
        tick();
        d_kill_i = 1'b0;
        #1;
        n_cmp++;
        if ({d_valid_o, d_stall_req_o} !== 2'b00) begin
            n_fail++; $display("FAIL kill_haz got v=%b req=%b want 0 0", d_valid_o, d_stall_req_o);
        end
        tick();
        n_cmp++;
        if ({d_valid_o, d_pc_o} !== {1'b1, 32'h0000_0804}) begin
            n_fail++; $display("FAIL kill_haz_nobubble got v=%b pc=%h want 1 804", d_valid_o, d_pc_o);
        end
    endtask

    task automatic test_illegal_reset();
        drive(32'hFFFF_FFFF, 32'h0000_0900);
        tick();
        n_cmp++;
        if ({d_valid_o, d_illegal_o, d_is_load_o, d_is_store_o, d_is_branch_o, d_is_jal_o, d_is_jalr_o, d_rd_o}
            !== {1'b1, 1'b1, 5'b00000, 5'd0}) begin
            n_fail++; $display("FAIL illegal got v=%b ill=%b flags=%b%b%b%b%b rd=%0d want 1 1 00000 0",
                               d_valid_o, d_illegal_o, d_is_load_o, d_is_store_o, d_is_branch_o,
                               d_is_jal_o, d_is_jalr_o, d_rd_o);
        end
        drive(32'h0050_0093, 32'h0000_0904); rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_cmp++;
        if ({d_valid_o, dut_obs()} !== {1'b0, obs_t'('0)}) begin
            n_fail++; $display("FAIL midreset got v=%b %h want 0 0", d_valid_o, dut_obs());
        end
    endtask

    task automatic test_random();
        logic held;
        held = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!held) begin
                f_ir_i = rand_ir(); f_pc_i = $urandom; f_valid_i = ($urandom_range(0, 9) != 0);
            end
            d_kill_i  = ($urandom_range(0, 19) == 0);
            d_stall_i = ($urandom_range(0, 6) == 0);
            rst_i     = ($urandom_range(0, 499) == 0);
            #1;
            n_cmp++;
            if ({d_stall_req_o, rf_rs1_o, rf_rs2_o} !== {model_stall_req(), f_ir_i[19:15], f_ir_i[24:20]}) begin
                n_fail++; $display("FAIL rand_comb cyc=%0d got req=%b rs=%0d/%0d want req=%b",
                                   c, d_stall_req_o, rf_rs1_o, rf_rs2_o, model_stall_req());
            end
            held = model_stall_req() && !d_kill_i;
            tick();
            n_cmp++;
            if (d_valid_o !== m_valid) begin
                n_fail++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", c, d_valid_o, m_valid);
            end
            if (m_valid) begin
                n_cmp++;
                if (dut_obs() !== m_obs) begin
                    n_fail++; $display("FAIL rand_fields cyc=%0d got=%h want=%h", c, dut_obs(), m_obs);
                end
            end
        end
        rst_i = 1'b0; d_kill_i = 1'b0; d_stall_i = 1'b0;
    endtask

    initial begin
        m_valid = 1'b0; m_obs = '0;
        rst_i = 1'b1; f_ir_i = 32'h0; f_pc_i = 32'h0; f_valid_i = 1'b0;
        d_stall_i = 1'b0; d_kill_i = 1'b0;
        test_reset();
        test_addi();
        test_load_use();
        test_branch();
        test_stall();
        test_kill();
        test_illegal_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
